// File: rtl/csi_dbg_pkg.sv
// Shared definitions for the frame dump sequencer: state encoding,
// header byte constants and byte-selection helpers.
package csi_dbg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEADER = 3'd1,
    ST_FETCH  = 3'd2,
    ST_SEND   = 3'd3,
    ST_CKSUM  = 3'd4,
    ST_DONE   = 3'd5
  } dump_state_e;

  localparam int unsigned HDR_LEN = 4;
  localparam logic [7:0]  HDR_B0  = 8'hFF;
  localparam logic [7:0]  HDR_B1  = 8'h00;
  localparam logic [7:0]  HDR_B2  = 8'hFF;
  localparam logic [7:0]  HDR_B3  = 8'hA5;

  // Header byte for position idx of the sync preamble.
  function automatic logic [7:0] header_byte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = HDR_B0;
      2'd1:    b = HDR_B1;
      2'd2:    b = HDR_B2;
      default: b = HDR_B3;
    endcase
    return b;
  endfunction

  // Byte idx of a word, MSB first (idx 0 -> [31:24]).
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_pacer.sv
// Idle-gap counter and byte-issue gate for the UART byte stream.
module uart_pacer #(
  parameter int unsigned HOLDOFF_W = 13
) (
  input  logic clk,
  input  logic rst,
  input  logic uart_busy_i,
  input  logic wr,
  output logic ready
);

  localparam logic [HOLDOFF_W-1:0] CNT_MAX = '1;

  logic [HOLDOFF_W-1:0] cnt_r;

  // Count quiet cycles since the UART last worked; saturate at all ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (uart_busy_i || wr) begin
      cnt_r <= '0;
    end else if (cnt_r != CNT_MAX) begin
      cnt_r <= cnt_r + {{(HOLDOFF_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign ready = (cnt_r == CNT_MAX) && !uart_busy_i && !wr;

endmodule

// File: rtl/frame_dump_seq.sv
// Frame dump sequencer: streams a header, every buffer word (MSB first)
// and a mod-256 payload checksum out through a paced UART byte interface.
module frame_dump_seq
  import csi_dbg_pkg::*;
#(
  parameter int unsigned COLS      = 40,
  parameter int unsigned ROWS      = 30,
  parameter int unsigned RD_LAT    = 2,
  parameter int unsigned HOLDOFF_W = 13,
  parameter int unsigned FREE_RUN  = 1
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic        start_i,
  output logic [5:0]  read_x_o,
  output logic [4:0]  read_y_o,
  input  logic [31:0] read_q_i,
  input  logic        uart_busy_i,
  output logic        uart_wr_o,
  output logic [7:0]  uart_dat_o,
  output logic        busy_o,
  output logic        frame_done_o
);

  localparam int unsigned LAT_W    = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT);
  localparam logic [5:0] X_LAST   = 6'(COLS - 1);
  localparam logic [4:0] Y_LAST   = 5'(ROWS - 1);
  localparam logic [1:0] HDR_LAST = 2'(HDR_LEN - 1);

  dump_state_e      state_r, state_s;
  logic [5:0]       x_r, x_s;
  logic [4:0]       y_r, y_s;
  logic [1:0]       idx_r, idx_s;
  logic [LAT_W-1:0] lat_r, lat_s;
  logic [31:0]      word_r, word_s;
  logic [7:0]       sum_r, sum_s;
  logic             wr_r, wr_s;
  logic [7:0]       dat_r, dat_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic [7:0]       pay_byte_s;
  logic             ready;

  uart_pacer #(.HOLDOFF_W(HOLDOFF_W)) u_pacer (
    .clk         (sys_clk_i),
    .rst         (sys_rst_i),
    .uart_busy_i (uart_busy_i),
    .wr          (wr_r),
    .ready       (ready)
  );

  // State and output registers; reset wins over everything.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_r <= ST_IDLE;
      x_r     <= 6'd0;
      y_r     <= 5'd0;
      idx_r   <= 2'd0;
      lat_r   <= '0;
      word_r  <= 32'd0;
      sum_r   <= 8'd0;
      wr_r    <= 1'b0;
      dat_r   <= 8'h00;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      x_r     <= x_s;
      y_r     <= y_s;
      idx_r   <= idx_s;
      lat_r   <= lat_s;
      word_r  <= word_s;
      sum_r   <= sum_s;
      wr_r    <= wr_s;
      dat_r   <= dat_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  // Next-state and next-output decisions; bytes leave only when the pacer is ready.
  always_comb begin
    state_s    = state_r;
    x_s        = x_r;
    y_s        = y_r;
    idx_s      = idx_r;
    lat_s      = lat_r;
    word_s     = word_r;
    sum_s      = sum_r;
    wr_s       = 1'b0;
    dat_s      = dat_r;
    done_s     = 1'b0;
    pay_byte_s = word_byte(word_r, idx_r);
    case (state_r)
      ST_IDLE: begin
        if ((FREE_RUN != 0) || start_i) begin
          state_s = ST_HEADER;
          sum_s   = 8'd0;
          idx_s   = 2'd0;
          x_s     = 6'd0;
          y_s     = 5'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_HEADER: begin
        if (ready) begin
          wr_s  = 1'b1;
          dat_s = header_byte(idx_r);
          idx_s = idx_r + 2'd1;
          if (idx_r == HDR_LAST) begin
            state_s = ST_FETCH;
            lat_s   = '0;
          end else begin
            state_s = ST_HEADER;
          end
        end else begin
          state_s = ST_HEADER;
        end
      end
      ST_FETCH: begin
        // Address has been stable since entry; take the word once it has settled.
        if (lat_r == LAT_LAST) begin
          word_s  = read_q_i;
          idx_s   = 2'd0;
          state_s = ST_SEND;
        end else begin
          lat_s   = lat_r + {{(LAT_W-1){1'b0}}, 1'b1};
          state_s = ST_FETCH;
        end
      end
      ST_SEND: begin
        if (ready) begin
          wr_s  = 1'b1;
          dat_s = pay_byte_s;
          sum_s = sum_r + pay_byte_s;
          idx_s = idx_r + 2'd1;
          if (idx_r == 2'd3) begin
            lat_s = '0;
            if (x_r == X_LAST) begin
              x_s = 6'd0;
              if (y_r == Y_LAST) begin
                y_s     = 5'd0;
                state_s = ST_CKSUM;
              end else begin
                y_s     = y_r + 5'd1;
                state_s = ST_FETCH;
              end
            end else begin
              x_s     = x_r + 6'd1;
              state_s = ST_FETCH;
            end
          end else begin
            state_s = ST_SEND;
          end
        end else begin
          state_s = ST_SEND;
        end
      end
      ST_CKSUM: begin
        if (ready) begin
          wr_s    = 1'b1;
          dat_s   = sum_r;
          done_s  = 1'b1;
          state_s = ST_DONE;
        end else begin
          state_s = ST_CKSUM;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  assign read_x_o     = x_r;
  assign read_y_o     = y_r;
  assign uart_wr_o    = wr_r;
  assign uart_dat_o   = dat_r;
  assign busy_o       = busy_r;
  assign frame_done_o = done_r;

endmodule
